// File: rtl/uart_pkg.sv
// Shared rate table and increment arithmetic for the fractional baud generator.
package uart_pkg;

   typedef logic [2:0] baud_sel_t;

   localparam int unsigned NUM_RATES = 8;

   localparam longint unsigned BAUD_TABLE [NUM_RATES] = '{
      64'd300, 64'd1200, 64'd4800, 64'd9600,
      64'd19200, 64'd38400, 64'd57600, 64'd115200
   };

   // round(baud * os * 2^acc_w / clk_hz), kept in 64 bits so it folds at elaboration.
   function automatic logic [63:0] calc_inc(
      input longint unsigned baud,
      input longint unsigned clk_hz,
      input int unsigned     os,
      input int unsigned     acc_w
   );
      longint unsigned num;
      num = (baud * longint'(os)) << acc_w;
      return (num + (clk_hz / 64'd2)) / clk_hz;
   endfunction

endpackage

// File: rtl/baud_rate_generator_if.sv
// Control and strobe bundle between the baud generator and the UART blocks.
interface baud_rate_generator_if
   import uart_pkg::*;
#(
   parameter int unsigned OVERSAMPLE = 16
);

   localparam int unsigned IDX_W = $clog2(OVERSAMPLE);

   logic             enable;
   baud_sel_t        baud_select;
   logic             restart;
   logic             sample_ENABLE;
   logic             tx_ENABLE;
   logic             mid_sample;
   logic [IDX_W-1:0] sample_index;

   modport master (
      output enable,
      output baud_select,
      output restart,
      input  sample_ENABLE,
      input  tx_ENABLE,
      input  mid_sample,
      input  sample_index
   );

   modport slave (
      input  enable,
      input  baud_select,
      input  restart,
      output sample_ENABLE,
      output tx_ENABLE,
      output mid_sample,
      output sample_index
   );

endinterface

// File: rtl/baud_rate_generator_phase_accumulator.sv
// Phase accumulator: wraps modulo 2^ACC_W, reports the wrap combinationally and registered.
module phase_accumulator #(
   parameter int unsigned ACC_W = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             clear,
   input  logic             advance,
   input  logic [ACC_W-1:0] inc,
   output logic             wrap,
   output logic             carry
);

   logic [ACC_W-1:0] acc;
   logic [ACC_W:0]   sum;

   assign sum  = {1'b0, acc} + {1'b0, inc};
   assign wrap = sum[ACC_W];

   always_ff @(posedge clk) begin
      if (reset || clear) begin
         acc   <= '0;
         carry <= 1'b0;
      end else if (advance) begin
         acc   <= sum[ACC_W-1:0];
         carry <= wrap;
      end else begin
         carry <= 1'b0;
      end
   end

endmodule

// File: rtl/baud_rate_generator.sv
// Fractional baud generator: oversample, bit and mid-bit strobes plus in-bit sample index.
module baud_rate_generator
   import uart_pkg::*;
#(
   parameter longint unsigned CLK_HZ     = 50_000_000,
   parameter int unsigned     OVERSAMPLE = 16,
   parameter int unsigned     ACC_W      = 32
) (
   input logic                   clk,
   input logic                   reset,
   baud_rate_generator_if.slave  bus
);

   localparam int unsigned CNT_W = $clog2(OVERSAMPLE);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
   localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(OVERSAMPLE / 2);

   if (OVERSAMPLE < 4 || (OVERSAMPLE & (OVERSAMPLE - 1)) != 0) begin : g_bad_os
      $error("OVERSAMPLE must be a power of two and at least 4");
   end

   if (ACC_W < 2 || ACC_W > 63) begin : g_bad_accw
      $error("ACC_W must be in 2..63");
   end

   logic [ACC_W-1:0] inc_rom [NUM_RATES];

   for (genvar s = 0; s < NUM_RATES; s++) begin : g_rom
      localparam logic [63:0] INC64 = calc_inc(BAUD_TABLE[s], CLK_HZ, OVERSAMPLE, ACC_W);
      assign inc_rom[s] = INC64[ACC_W-1:0];
      if (INC64 == 64'd0 || INC64 >= (64'd1 << ACC_W)) begin : g_bad_inc
         $error("baud increment out of range for accumulator width");
      end
   end

   baud_sel_t        sel_q;
   logic [CNT_W-1:0] cnt;
   logic [CNT_W-1:0] cnt_next;
   logic             tx_q;
   logic             mid_q;
   logic             realign;
   logic             wrap;
   logic             carry;
   logic [ACC_W-1:0] inc;

   // Restart and a rate change share one path: both zero the phase and the count.
   assign realign  = bus.restart || (bus.baud_select != sel_q);
   assign inc      = inc_rom[sel_q];
   assign cnt_next = cnt + CNT_ONE;

   phase_accumulator #(
      .ACC_W(ACC_W)
   ) u_phase (
      .clk     (clk),
      .reset   (reset),
      .clear   (realign),
      .advance (bus.enable),
      .inc     (inc),
      .wrap    (wrap),
      .carry   (carry)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         sel_q <= bus.baud_select;
         cnt   <= '0;
         tx_q  <= 1'b0;
         mid_q <= 1'b0;
      end else begin
         tx_q  <= 1'b0;
         mid_q <= 1'b0;
         if (realign) begin
            sel_q <= bus.baud_select;
            cnt   <= '0;
         end else if (bus.enable && wrap) begin
            cnt   <= cnt_next;
            tx_q  <= (cnt_next == '0);
            mid_q <= (cnt_next == CNT_HALF);
         end
      end
   end

   // The registered accumulator carry is the oversample strobe itself.
   assign bus.sample_ENABLE = carry;
   assign bus.tx_ENABLE     = tx_q;
   assign bus.mid_sample    = mid_q;
   assign bus.sample_index  = cnt;

endmodule
